// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array read-out path: default geometry,
// drain FSM states, drain length and the per-PE control-vector index helper.
package sa_pkg;

    localparam int N_DEF        = 32;
    localparam int ROWS_DEF     = 5;
    localparam int COLS_DEF     = 5;
    localparam int DRAIN_CYCLES = ROWS_DEF + 1;
    localparam int ROW_W        = 3;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        OUT
    } sa_state_e;

    // Bit position of PE(r, c) inside a clr/read/write control vector.
    function automatic int pe_idx(input int r, input int c);
        return r * COLS_DEF + c;
    endfunction

endpackage

// File: rtl/sa_row_buffer.sv
// Result buffer for the drain collector: ROWS entries of one full result row,
// one write port fed by drain capture and one combinational read port.
module sa_row_buffer
    import sa_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ROW_W-1:0]     waddr,
    input  logic [COLS*N-1:0]    wdata,
    input  logic [ROW_W-1:0]     raddr,
    output logic [COLS*N-1:0]    rdata
);

    logic [COLS*N-1:0] mem_q [ROWS];
    logic [COLS*N-1:0] mem_d [ROWS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: storage is deliberately left without reset; every entry is
    // written during a drain before it is ever presented to the consumer.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/systolic_drain_collector.sv
// Drains a ROWS x COLS output-stationary array through its B chain and streams
// the result matrix out row by row. Build option: SA_DRAIN_CLR_EN (park cycle clears the array).
module systolic_drain_collector
    import sa_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int M    = ROWS * COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 start_ready,
    output logic                 drain_busy,
    output logic [M-1:0]         clr_o,
    output logic [M-1:0]         read_o,
    output logic [M-1:0]         write_o,
    input  logic [COLS*N-1:0]    col_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ROW_W-1:0]     res_row,
    output logic [COLS*N-1:0]    res_data
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    sa_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  ptr_q, ptr_d;
    logic              drain_busy_q, drain_busy_d;
    logic [M-1:0]      clr_q, clr_d;
    logic [M-1:0]      read_q, read_d;
    logic [M-1:0]      write_q, write_d;

    logic              cap_we;
    logic [ROW_W-1:0]  cap_addr;

    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = OUT;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (ptr_q == LAST_ROW) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Controls are decoded from the next state so the registered outputs
    // line up with the drain cycle they belong to.
    always_comb begin
        drain_busy_d = (state_d == DRAIN);
        clr_d        = '0;
        read_d       = '0;
        write_d      = '0;
        if (state_d == DRAIN) begin
            if (cnt_d == LAST_CNT) begin
`ifdef SA_DRAIN_CLR_EN
                clr_d  = '1;
`else
                read_d = '1;
`endif
            end else begin
                read_d  = '1;
                write_d = '1;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            drain_busy_q <= 1'b0;
            clr_q        <= '0;
            read_q       <= '0;
            write_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            drain_busy_q <= drain_busy_d;
            clr_q        <= clr_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    // The bottom row shows PE row ROWS-k during drain cycle k (k >= 1).
    assign cap_we   = (state_q == DRAIN) && (cnt_q != '0);
    assign cap_addr = ROW_W'(ROWS) - ROW_W'(cnt_q);

    sa_row_buffer #(
        .N    (N),
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_buffer (
        .clk   (clk),
        .we    (cap_we),
        .waddr (cap_addr),
        .wdata (col_in),
        .raddr (ptr_q),
        .rdata (res_data)
    );

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == OUT);
    assign res_row     = ptr_q;
    assign drain_busy  = drain_busy_q;
    assign clr_o       = clr_q;
    assign read_o      = read_q;
    assign write_o     = write_q;

endmodule

// File: tb/tb_systolic_drain_collector.sv
// Directed bench for systolic_drain_collector with a behavioural 5x5 array
// model on the B chain; expectations follow SA_DRAIN_CLR_EN when defined.
module tb_systolic_drain_collector;
    import sa_pkg::*;

    localparam int N    = 32;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int M    = ROWS * COLS;
    localparam int W    = COLS * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            start_ready;
    logic            drain_busy;
    logic [M-1:0]    clr_o;
    logic [M-1:0]    read_o;
    logic [M-1:0]    write_o;
    logic [W-1:0]    col_in;
    logic            res_valid;
    logic            res_ready;
    logic [2:0]      res_row;
    logic [W-1:0]    res_data;

    int checks = 0;
    int errors = 0;

    systolic_drain_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .drain_busy  (drain_busy),
        .clr_o       (clr_o),
        .read_o      (read_o),
        .write_o     (write_o),
        .col_in      (col_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_row     (res_row),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Array model: a read shifts each row's Acc down one row (row 0 takes the
    // forced-zero B input), a write copies Acc into Bout, clr zeroes the PE.
    logic [N-1:0] acc  [ROWS][COLS];
    logic [N-1:0] aout [ROWS][COLS];
    logic [N-1:0] bout [ROWS][COLS];
    logic [N-1:0] pre_acc [ROWS][COLS];
    logic         load_req = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (load_req) begin
                    acc[r][c]  <= pre_acc[r][c];
                    aout[r][c] <= 32'h1;
                    bout[r][c] <= 32'hBAD0_0000 | 32'(pe_idx(r, c));
                end else if (clr_o[pe_idx(r, c)]) begin
                    acc[r][c]  <= '0;
                    aout[r][c] <= '0;
                    bout[r][c] <= '0;
                end else begin
                    if (read_o[pe_idx(r, c)])
                        acc[r][c] <= (r == 0) ? '0 : acc[r-1][c];
                    if (write_o[pe_idx(r, c)])
                        bout[r][c] <= acc[r][c];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++)
            col_in[c*N +: N] = bout[ROWS-1][c];
    end

    task automatic preload(input int kind);
        @(negedge clk);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    0:       pre_acc[r][c] = 32'(10 * r + c);
                    1:       pre_acc[r][c] = 32'(100 + r);
                    default: pre_acc[r][c] = ((r + c) % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                endcase
            end
        end
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    function automatic logic [N-1:0] model_or(input bit with_aout_bout);
        logic [N-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                v |= acc[r][c];
                if (with_aout_bout) v |= aout[r][c] | bout[r][c];
            end
        return v;
    endfunction

    // One full drain + read-out. Rows are compared against a snapshot of the
    // model taken before the drain; stall holds res_ready low at row 1.
    task automatic do_drain(input string tag, input int stall, input bit poke,
                            input bit use_hand, input logic [W-1:0] hand_row2);
        logic [N-1:0] exp [ROWS][COLS];
        logic [W-1:0] exp_row;
        int  got = 0, busy = 0, first_valid = -1, done = -1, stall_left = stall;
        bit  rdy;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp[r][c] = acc[r][c];
        @(negedge clk);
        start     = 1'b1;
        res_ready = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 9);
            busy += int'(drain_busy);
            if (cyc == 1) begin
                check({tag, "_c1_read"},  W'(read_o),  W'({M{1'b1}}));
                check({tag, "_c1_write"}, W'(write_o), W'({M{1'b1}}));
                check({tag, "_c1_clr"},   W'(clr_o),   W'(0));
            end
            if (cyc == 6) begin
`ifdef SA_DRAIN_CLR_EN
                check({tag, "_c6_clr"},   W'(clr_o),   W'({M{1'b1}}));
                check({tag, "_c6_read"},  W'(read_o),  W'(0));
`else
                check({tag, "_c6_clr"},   W'(clr_o),   W'(0));
                check({tag, "_c6_read"},  W'(read_o),  W'({M{1'b1}}));
`endif
                check({tag, "_c6_write"}, W'(write_o), W'(0));
            end
            if (res_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (got < ROWS) begin
                    for (int c = 0; c < COLS; c++) exp_row[c*N +: N] = exp[got][c];
                    check($sformatf("%s_row%0d_idx", tag, got), W'(res_row), W'(got));
                    check($sformatf("%s_row%0d_data", tag, got), res_data, exp_row);
                    if (use_hand && got == 2)
                        check({tag, "_row2_hand"}, res_data, hand_row2);
                end else begin
                    check({tag, "_extra_valid"}, W'(res_valid), W'(0));
                end
            end
            rdy = !(got == 1 && stall_left > 0);
            if (!rdy) stall_left--;
            res_ready = rdy;
            if (res_valid && rdy) got++;
            if (done < 0 && got == ROWS && start_ready) done = cyc;
            if (done > 0 && cyc == done + 3) break;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        check({tag, "_first_valid_cyc"}, W'(first_valid), W'(7));
        check({tag, "_rows_received"},   W'(got),         W'(ROWS));
        check({tag, "_busy_cycles"},     W'(busy),        W'(6));
        check({tag, "_idle_cyc"},        W'(done),        W'(12 + stall));
        check({tag, "_acc_zero"},        W'(model_or(1'b0)), W'(0));
`ifdef SA_DRAIN_CLR_EN
        check({tag, "_all_zero"},        W'(model_or(1'b1)), W'(0));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        #12;
        check("rst_start_ready", W'(start_ready), W'(1));
        check("rst_busy",        W'(drain_busy),  W'(0));
        check("rst_ctrl",        W'(clr_o | read_o | write_o), W'(0));
        check("rst_valid",       W'(res_valid),   W'(0));
        check("rst_row",         W'(res_row),     W'(0));
        @(negedge clk);
        rst = 1'b0;

        preload(0);
        do_drain("basic", 0, 1'b0, 1'b1,
                 {32'd24, 32'd23, 32'd22, 32'd21, 32'd20});

        preload(0);
        do_drain("stall", 3, 1'b1, 1'b0, '0);

        preload(1);
        do_drain("fresh", 0, 1'b0, 1'b0, '0);

        // Reset while the drain sits at cnt=3 (cycle 4 after acceptance).
        preload(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", W'(drain_busy), W'(1));
        rst = 1'b1;
        #1;
        check("mid_ctrl_async", W'(clr_o | read_o | write_o), W'(0));
        check("mid_busy_async", W'(drain_busy), W'(0));
        @(negedge clk);
        rst = 1'b0;
        check("mid_start_ready", W'(start_ready), W'(1));
        check("mid_valid",       W'(res_valid),   W'(0));
        preload(1);
        do_drain("after_rst", 0, 1'b0, 1'b0, '0);

        preload(2);
        do_drain("extremes", 0, 1'b0, 1'b1,
                 {32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
